// File: rtl/ex_stage.sv
// Execute stage: single-cycle RV32I ALU feeding the EX/MEM register.
// Define EX_DIV_EN to add the 32-iteration restoring divider (DIV/DIVU/REM/REMU) with upstream stall.
module ex_stage #(
  parameter int XLEN      = 32,
  parameter int DIV_CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] id_ex_reg_op_a_i,
  input  logic [XLEN-1:0] id_ex_reg_op_b_i,
  input  logic [3:0]      id_ex_reg_aluop_i,
  input  logic            id_ex_reg_valid_i,
  input  logic            ex_flush_i,
  output logic [XLEN-1:0] ex_result_o,
  output logic            ex_valid_o,
  output logic            ex_stall_o
);

  logic [XLEN-1:0]      op_a;
  logic [XLEN-1:0]      op_b;
  logic [XLEN-1:0]      alu_result;
  logic [DIV_CNT_W-1:0] shamt;

  assign op_a  = id_ex_reg_op_a_i;
  assign op_b  = id_ex_reg_op_b_i;
  // Shift amount is log2(XLEN) bits wide, the same width as the divider counter.
  assign shamt = op_b[DIV_CNT_W-1:0];

  always_comb begin
    alu_result = '0;
    case (id_ex_reg_aluop_i)
      4'd0:    alu_result = op_a + op_b;
      4'd1:    alu_result = op_a - op_b;
      4'd2:    alu_result = op_a & op_b;
      4'd3:    alu_result = op_a | op_b;
      4'd4:    alu_result = op_a ^ op_b;
      4'd5:    alu_result = op_a << shamt;
      4'd6:    alu_result = op_a >> shamt;
      4'd7:    alu_result = $unsigned($signed(op_a) >>> shamt);
      4'd8:    alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'd9:    alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
      default: alu_result = '0;
    endcase
  end

`ifdef EX_DIV_EN
  localparam logic [0:0]      IDLE    = 1'b0;
  localparam logic [0:0]      CALC    = 1'b1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [0:0]           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [XLEN-1:0]      quo_q;
  logic [XLEN-1:0]      rem_q;
  logic [XLEN-1:0]      dvsr_q;
  logic                 rem_sel_q;
  logic                 negate_q;

  logic            is_div_op;
  logic            is_signed_div;
  logic            is_rem_op;
  logic            div_by_zero;
  logic            div_overflow;
  logic            div_start;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] special_result;
  logic [XLEN-1:0] issue_result;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   rem_trial;
  logic            trial_ok;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] div_raw;

  assign is_div_op     = (id_ex_reg_aluop_i >= 4'd10) && (id_ex_reg_aluop_i <= 4'd13);
  assign is_signed_div = (id_ex_reg_aluop_i == 4'd10) || (id_ex_reg_aluop_i == 4'd12);
  assign is_rem_op     = (id_ex_reg_aluop_i == 4'd12) || (id_ex_reg_aluop_i == 4'd13);
  assign div_by_zero   = is_div_op && (op_b == '0);
  assign div_overflow  = is_signed_div && (op_a == INT_MIN) && (op_b == '1);
  assign div_start     = (state == IDLE) && id_ex_reg_valid_i && is_div_op &&
                         !div_by_zero && !div_overflow;

  assign mag_a = (is_signed_div && op_a[XLEN-1]) ? -op_a : op_a;
  assign mag_b = (is_signed_div && op_b[XLEN-1]) ? -op_b : op_b;

  // Divide-by-zero and signed overflow finish like ordinary ALU ops, never entering CALC.
  always_comb begin
    special_result = '0;
    if (div_by_zero)
      special_result = is_rem_op ? op_a : '1;
    else if (div_overflow)
      special_result = is_rem_op ? '0 : INT_MIN;
  end

  assign issue_result = (div_by_zero || div_overflow) ? special_result : alu_result;

  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_trial = rem_shift - {1'b0, dvsr_q};
  assign trial_ok  = ~rem_trial[XLEN];
  assign quo_next  = {quo_q[XLEN-2:0], trial_ok};
  assign rem_next  = trial_ok ? rem_trial[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign div_raw   = rem_sel_q ? rem_next : quo_next;

  assign ex_stall_o = !rst && !ex_flush_i && ((state == CALC) || div_start);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvsr_q      <= '0;
      rem_sel_q   <= 1'b0;
      negate_q    <= 1'b0;
      ex_result_o <= '0;
      ex_valid_o  <= 1'b0;
    end else begin
      ex_valid_o <= 1'b0;
      if (ex_flush_i) begin
        state <= IDLE;
      end else if (state == CALC) begin
        quo_q <= quo_next;
        rem_q <= rem_next;
        cnt   <= cnt + 1'b1;
        if (cnt == '1) begin
          ex_result_o <= negate_q ? -div_raw : div_raw;
          ex_valid_o  <= 1'b1;
          state       <= IDLE;
        end
      end else if (id_ex_reg_valid_i) begin
        if (div_start) begin
          quo_q     <= mag_a;
          rem_q     <= '0;
          dvsr_q    <= mag_b;
          cnt       <= '0;
          rem_sel_q <= is_rem_op;
          // Remainder follows the dividend's sign; quotient is negative when the signs differ.
          negate_q  <= is_signed_div &&
                       (is_rem_op ? op_a[XLEN-1] : (op_a[XLEN-1] ^ op_b[XLEN-1]));
          state     <= CALC;
        end else begin
          ex_result_o <= issue_result;
          ex_valid_o  <= 1'b1;
        end
      end
    end
  end
`else
  assign ex_stall_o = 1'b0;

  // Without the divider every opcode, including 10-13, completes one cycle after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_result_o <= '0;
      ex_valid_o  <= 1'b0;
    end else begin
      ex_valid_o <= 1'b0;
      if (id_ex_reg_valid_i && !ex_flush_i) begin
        ex_result_o <= alu_result;
        ex_valid_o  <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed plan steps plus randomized ops against an arithmetic model.
// Divider scenarios are exercised when EX_DIV_EN is defined; otherwise ops 10-15 are checked as reserved.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  aluop;
  logic        valid;
  logic        flush;
  logic [31:0] ex_result;
  logic        ex_valid;
  logic        ex_stall;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_result = 32'd0;

  ex_stage dut (
    .clk               (clk),
    .rst               (rst),
    .id_ex_reg_op_a_i  (op_a),
    .id_ex_reg_op_b_i  (op_b),
    .id_ex_reg_aluop_i (aluop),
    .id_ex_reg_valid_i (valid),
    .ex_flush_i        (flush),
    .ex_result_o       (ex_result),
    .ex_valid_o        (ex_valid),
    .ex_stall_o        (ex_stall)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic v, input logic f);
    aluop = op;
    op_a  = a;
    op_b  = b;
    valid = v;
    flush = f;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Architectural result computed with plain 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = 0;
    case (op)
      4'd0: r = ua + ub;
      4'd1: r = ua - ub;
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = ua << b[4:0];
      4'd6: r = ua >> b[4:0];
      4'd7: r = sa >>> b[4:0];
      4'd8: r = (sa < sb) ? 1 : 0;
      4'd9: r = (ua < ub) ? 1 : 0;
`ifdef EX_DIV_EN
      4'd10: r = (b == 32'd0) ? -1 : sa / sb;
      4'd11: r = (b == 32'd0) ? -1 : ua / ub;
      4'd12: r = (b == 32'd0) ? sa : sa % sb;
      4'd13: r = (b == 32'd0) ? ua : ua % ub;
`endif
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  // Issue one instruction that must finish next cycle without stalling.
  task automatic run_quick(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] expected;
    expected = ref_model(op, a, b);
    applyStimulus(op, a, b, 1'b1, 1'b0);
    #1;
    checkOutput({tag, "_stall"}, {31'd0, ex_stall}, 32'd0);
    tick;
    checkOutput({tag, "_valid"}, {31'd0, ex_valid}, 32'd1);
    checkOutput({tag, "_result"}, ex_result, expected);
    last_result = expected;
  endtask

`ifdef EX_DIV_EN
  // Issue a long divide, hold ID/EX while stalled, and expect completion in cycle N+33.
  task automatic run_divide(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] expected;
    int stall_cycles;
    int early_valids;
    expected = ref_model(op, a, b);
    applyStimulus(op, a, b, 1'b1, 1'b0);
    #1;
    checkOutput({tag, "_stall_issue"}, {31'd0, ex_stall}, 32'd1);
    stall_cycles = 1;
    early_valids = 0;
    for (int k = 1; k <= 32; k++) begin
      tick;
      if (ex_stall) stall_cycles++;
      if (ex_valid) early_valids++;
    end
    checkOutput({tag, "_stall_cycles"}, stall_cycles, 32'd33);
    checkOutput({tag, "_early_valid"}, early_valids, 32'd0);
    tick;
    checkOutput({tag, "_valid"}, {31'd0, ex_valid}, 32'd1);
    checkOutput({tag, "_result"}, ex_result, expected);
    last_result = expected;
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    checkOutput({tag, "_stall_done"}, {31'd0, ex_stall}, 32'd0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic        rv;
    int          spurious;

    rst = 1'b1;
    applyStimulus(4'd10, 32'd20, 32'd3, 1'b1, 1'b0);
    #2;
    checkOutput("reset_result", ex_result, 32'd0);
    checkOutput("reset_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("reset_stall", {31'd0, ex_stall}, 32'd0);
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #10;
    rst = 1'b0;
    tick;
    checkOutput("idle_valid", {31'd0, ex_valid}, 32'd0);

    // ALU sweep, issued back-to-back
    run_quick("add_wrap", 4'd0, 32'h7FFF_FFFF, 32'd1);
    run_quick("sub_neg", 4'd1, 32'd0, 32'd1);
    run_quick("sra", 4'd7, 32'h8000_0000, 32'd4);
    run_quick("slt", 4'd8, 32'hFFFF_FFFF, 32'd1);
    run_quick("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1);
    run_quick("reserved14", 4'd14, 32'h1234_5678, 32'd9);

    // Randomized ALU traffic with occasional bubbles
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) rop = 4'($urandom_range(14, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rv = ($urandom_range(0, 7) != 0);
      if (rv) begin
        run_quick("rand_alu", rop, ra, rb);
      end else begin
        applyStimulus(rop, ra, rb, 1'b0, 1'b0);
        tick;
        checkOutput("rand_bubble_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("rand_bubble_hold", ex_result, last_result);
      end
    end

    // Flush in IDLE drops the instruction and never stalls
    applyStimulus(4'd10, 32'hFFFF_FFEC, 32'd3, 1'b1, 1'b1);
    #1;
    checkOutput("flush_idle_stall", {31'd0, ex_stall}, 32'd0);
    tick;
    checkOutput("flush_idle_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("flush_idle_hold", ex_result, last_result);

`ifdef EX_DIV_EN
    run_divide("div_m20_3", 4'd10, 32'hFFFF_FFEC, 32'd3);
    run_divide("rem_m20_3", 4'd12, 32'hFFFF_FFEC, 32'd3);

    run_quick("divu_by0", 4'd11, 32'd5, 32'd0);
    run_quick("rem_by0", 4'd12, 32'd5, 32'd0);
    run_quick("div_ovf", 4'd10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_quick("rem_ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush at N+10 of a DIVU
    applyStimulus(4'd11, 32'd100, 32'd7, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) tick;
    applyStimulus(4'd11, 32'd100, 32'd7, 1'b1, 1'b1);
    tick;
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    checkOutput("flush_calc_stall", {31'd0, ex_stall}, 32'd0);
    checkOutput("flush_calc_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("flush_calc_hold", ex_result, last_result);
    spurious = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (ex_valid) spurious++;
    end
    checkOutput("flush_calc_no_valid", spurious, 32'd0);
    run_quick("add_after_flush", 4'd0, 32'd1, 32'd1);

    // Asynchronous reset at N+5, between edges
    applyStimulus(4'd11, 32'd100, 32'd7, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) tick;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_result", ex_result, 32'd0);
    checkOutput("arst_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("arst_stall", {31'd0, ex_stall}, 32'd0);
    last_result = 32'd0;
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick;
    #2;
    rst = 1'b0;
    spurious = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (ex_valid) spurious++;
    end
    checkOutput("arst_no_valid", spurious, 32'd0);
    run_divide("divu_100_7", 4'd11, 32'd100, 32'd7);

    // Randomized long divides, including sign combinations
    for (int i = 0; i < 6; i++) begin
      rop = 4'($urandom_range(10, 13));
      ra  = $urandom;
      rb  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if ($urandom_range(0, 1) == 0) rb = -rb;
      if (rb == 32'd0) rb = 32'd3;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd5;
      run_divide("rand_div", rop, ra, rb);
    end
`else
    run_quick("div_disabled", 4'd10, 32'd10, 32'd2);
    for (int i = 0; i < 8; i++) begin
      rop = 4'($urandom_range(10, 15));
      run_quick("rand_reserved", rop, $urandom, $urandom);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
